// File: rtl/debug_trace_recorder_pkg.sv
// Shared types and default sizing for the debug trace recorder.
// The recorder FSM encoding is part of the external 'state' port.
package debug_trace_recorder_pkg;

  localparam int TRACE_STAMP_WIDTH         = 32;
  localparam int TRACE_DEFAULT_DEPTH       = 16;
  localparam int TRACE_DEFAULT_ENTRY_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_recorder_state_e;

endpackage

// File: rtl/trace_entry_ram.sv
// Trace storage: DEPTH x WIDTH, one synchronous write port and one
// asynchronous read port, so readout data has no extra latency.
module trace_entry_ram
  import debug_trace_recorder_pkg::*;
#(
  parameter int WIDTH = TRACE_DEFAULT_ENTRY_WIDTH,
  parameter int DEPTH = TRACE_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; a reset would turn it into DEPTH*WIDTH
  // reset flops and block mapping onto distributed RAM.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/debug_trace_recorder.sv
// Circular trace buffer that freezes around a trigger, keeping pre- and
// post-trigger entries, then streams the frozen window oldest-first.
module debug_trace_recorder
  import debug_trace_recorder_pkg::*;
#(
  parameter int ENTRY_WIDTH = TRACE_DEFAULT_ENTRY_WIDTH,
  parameter int DEPTH       = TRACE_DEFAULT_DEPTH,
  parameter int STAMP_WIDTH = TRACE_STAMP_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     abort,
  input  logic                     arm,
  input  logic                     trigger,
  input  logic [$clog2(DEPTH)-1:0] postCount,
  input  logic                     captureValid,
  input  logic [ENTRY_WIDTH-1:0]   captureData,
  input  logic                     readReady,
  output logic                     readValid,
  output logic [ENTRY_WIDTH-1:0]   readData,
  output logic                     readLast,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   entryCount,
  output logic [STAMP_WIDTH-1:0]   triggerStamp
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  trace_recorder_state_e r_state, w_state_nxt;
  logic [AW-1:0]          r_wr_ptr, w_wr_ptr_nxt;
  logic [AW-1:0]          r_rd_ptr, w_rd_ptr_nxt;
  logic [AW-1:0]          r_remaining, w_remaining_nxt;
  logic [CW-1:0]          r_entry_count, w_count_nxt;
  logic [STAMP_WIDTH-1:0] r_trigger_stamp, w_stamp_nxt;
  logic [STAMP_WIDTH-1:0] r_cycle;
  logic                   w_wr_en;
  logic                   w_handshake;
  logic [ENTRY_WIDTH-1:0] w_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // In DONE the entry count doubles as the number of entries left to read.
  assign w_handshake = readValid & readReady;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt     = r_state;
    w_wr_en         = 1'b0;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_remaining_nxt = r_remaining;
    w_count_nxt     = r_entry_count;
    w_stamp_nxt     = r_trigger_stamp;

    unique case (r_state)
      IDLE: begin
        if (arm) begin
          w_state_nxt  = ARMED;
          w_wr_ptr_nxt = '0;
          w_count_nxt  = '0;
        end
      end

      ARMED, POST: begin
        if (captureValid) begin
          w_wr_en      = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + AW'(1);
          if (r_entry_count != FULL_COUNT) w_count_nxt = r_entry_count + CW'(1);
        end
        if (r_state == ARMED && trigger) begin
          w_remaining_nxt = postCount;
          w_stamp_nxt     = r_cycle;
          w_state_nxt     = (postCount == '0) ? DONE : POST;
        end else if (r_state == POST && captureValid) begin
          w_remaining_nxt = r_remaining - AW'(1);
          if (r_remaining == AW'(1)) w_state_nxt = DONE;
        end
        // Oldest surviving entry sits entryCount slots behind the write pointer.
        if (w_state_nxt == DONE) w_rd_ptr_nxt = w_wr_ptr_nxt - w_count_nxt[AW-1:0];
      end

      DONE: begin
        if (r_entry_count == '0) begin
          w_state_nxt = IDLE;
        end else if (w_handshake) begin
          w_rd_ptr_nxt = r_rd_ptr + AW'(1);
          w_count_nxt  = r_entry_count - CW'(1);
          if (r_entry_count == CW'(1)) w_state_nxt = IDLE;
        end
      end
    endcase

    if (abort) begin
      w_state_nxt = IDLE;
      w_wr_en     = 1'b0;
      w_count_nxt = '0;
      w_stamp_nxt = r_trigger_stamp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_remaining     <= '0;
      r_entry_count   <= '0;
      r_trigger_stamp <= '0;
      r_cycle         <= '0;
    end else begin
      r_wr_ptr        <= w_wr_ptr_nxt;
      r_rd_ptr        <= w_rd_ptr_nxt;
      r_remaining     <= w_remaining_nxt;
      r_entry_count   <= w_count_nxt;
      r_trigger_stamp <= w_stamp_nxt;
      r_cycle         <= r_cycle + STAMP_WIDTH'(1);
    end
  end

  trace_entry_ram #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (captureData),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign readValid    = (r_state == DONE) && (r_entry_count != '0);
  assign readLast     = (r_state == DONE) && (r_entry_count == CW'(1));
  assign readData     = w_rd_data;
  assign state        = r_state;
  assign entryCount   = r_entry_count;
  assign triggerStamp = r_trigger_stamp;

endmodule

// File: doc/debug_trace_recorder.md
# debug_trace_recorder

Parametrised successor to the per-cycle debug register snapshot. It records a stream of debug entries into a circular buffer and freezes around a trigger event, keeping a programmable number of pre-trigger and post-trigger entries. The frozen window is then streamed out oldest-first over a valid/ready port. It sits beside the debug register path: it is fed a packed slice of the debug state (e.g. committed PC, pipeline-control bits) and is drained by the host or the simulation monitor.

## Interface
Parameters:
- ENTRY_WIDTH, 64: width of one recorded entry.
- DEPTH, 16: buffer entries; power of two, at least 2.
- STAMP_WIDTH, 32: width of the cycle counter and trigger timestamp.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- abort  in  1  synchronous return to IDLE from any state; highest priority.
- arm  in  1  pulse; starts recording. Honoured only in IDLE.
- trigger  in  1  trigger event. Honoured only in ARMED.
- postCount  in  $clog2(DEPTH)  number of entries to record after the trigger entry; sampled on the trigger cycle.
- captureValid  in  1  captureData is valid this cycle.
- captureData  in  ENTRY_WIDTH  entry to record.
- readReady  in  1  consumer accepts readData.
- readValid  out  1  readData is valid.
- readData  out  ENTRY_WIDTH  current entry being streamed, oldest first.
- readLast  out  1  readData is the final entry of the window.
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- entryCount  out  $clog2(DEPTH)+1  valid entries held; saturates at DEPTH.
- triggerStamp  out  STAMP_WIDTH  cycle-counter value latched on the accepted trigger.

## Operation
- A free-running cycle counter starts at 0 after reset and wraps modulo 2^STAMP_WIDTH.
- **IDLE:** nothing is written. When arm=1, next state is ARMED, and wrPtr and entryCount clear to 0.
- **ARMED:** when captureValid=1, captureData is written at wrPtr. wrPtr increments modulo DEPTH. entryCount increments and saturates at DEPTH. On wrap, the oldest entry is overwritten.
- **Accepted trigger (state ARMED, trigger=1):**
  - The entry captured in the same cycle, if any, is recorded and counts as the trigger entry.
  - remaining is loaded from postCount. postCount is at most DEPTH-1 by its width, so the trigger entry always survives.
  - triggerStamp latches the cycle counter.
  - If postCount=0, next state is DONE. Otherwise it is POST.
- **POST:**
  - Recording continues as in ARMED.
  - Each written entry decrements remaining. The write that brings remaining to 0 moves the state to DONE.
  - A cycle with captureValid=0 does not decrement remaining.
  - trigger is ignored.
- **DONE:** recording stops and the buffer is frozen.
  - On entry, rdPtr = (wrPtr - entryCount) mod DEPTH and readLeft = entryCount.
  - readValid = (readLeft != 0). readData = mem[rdPtr]. readLast = (readLeft == 1).
  - Each handshake (readValid & readReady) increments rdPtr modulo DEPTH and decrements readLeft. entryCount tracks readLeft.
  - The handshake with readLast=1 moves the state to IDLE.
  - If DONE is entered with entryCount=0, the state goes to IDLE the next cycle and readValid never asserts.
- **Ignored inputs:** arm outside IDLE, and trigger outside ARMED, are ignored.
- **abort:** next state is IDLE and entryCount clears to 0. triggerStamp is held. abort overrides arm, trigger and handshakes in the same cycle.
- **Reset values:**
  - state=IDLE.
  - wrPtr, rdPtr, remaining, readLeft, entryCount = 0.
  - readValid=0, readLast=0.
  - triggerStamp=0, cycle counter=0.
  - Buffer contents are not reset, so readData is don't-care while readValid=0.

## Timing
- A write on cycle N is readable from cycle N+1.
- All state and counter outputs are registered and update on the cycle after the causing input.
- readData and readLast are combinational from registered rdPtr, readLeft and the buffer. No extra read latency: data is valid in the same cycle as readValid.
- Trigger to DONE: one cycle plus the cycles taken to capture postCount valid entries.
- Throughput: one capture per cycle while recording; one entry per cycle during readout when readReady is held high.
- Reset asserted mid-operation aborts immediately, asynchronously.

## Structure
- DebugTypes gains:
  - the TraceRecorderState enum (IDLE, ARMED, POST, DONE);
  - TRACE_STAMP_WIDTH;
  - default depth and width constants.
- Sub-module trace_entry_ram holds the storage: DEPTH x ENTRY_WIDTH, one synchronous write port and one asynchronous read port, flop or distributed RAM. It has no reset.
- The FSM, pointers and counters live in debug_trace_recorder.

## Test plan
- **Basic window:** DEPTH=16. Arm, then capture 0..29 on every cycle, trigger on entry 20, postCount=3. Required: DONE with entryCount=16, and a readout of 8..23 with readLast on 23.
- **Trigger entry alone:** capture entries 1..5, then trigger with captureValid=1, data=6, postCount=0. Required: DONE next cycle, and a readout of 1..6 with 6 as the last entry.
- **Sparse post-trigger:** postCount=2 with captureValid toggling. Required: DONE only after two valid writes following the trigger, and triggerStamp equal to the cycle count at the trigger.
- **Readout backpressure and empty window:**
  - readReady toggling 1,0,1,0 during readout: every entry delivered exactly once, data stable while readReady=0, IDLE after the last handshake.
  - Trigger with no captures: DONE, then IDLE, with readValid never asserted.
- **abort:**
  - abort during POST: IDLE next cycle, entryCount=0.
  - abort and arm asserted together in IDLE: stays IDLE.
- **Asynchronous reset:** assert rst mid-readout. Required: every output at its reset value immediately, without waiting for a clock edge.
